// File: rtl/kbd_fifo_if.sv
// Keyboard FIFO bus bundle.
// Carries the PS/2 receiver handoff (ps2_data, ps2_toggle), the CPU output-port
// write bus (pin_pa, pin_po, pin_pw) and the keyboard status outputs
// (kb_code, kb_stat, kb_irq).
//   master : the CPU/receiver side; drives the inputs and reads the status.
//   slave  : kbd_fifo; reads the inputs and drives the status.
interface kbd_fifo_if;
  logic [7:0] ps2_data;
  logic       ps2_toggle;
  logic [7:0] pin_pa;
  logic [7:0] pin_po;
  logic       pin_pw;
  logic [7:0] kb_code;
  logic [7:0] kb_stat;
  logic       kb_irq;

  modport master (
    output ps2_data, ps2_toggle, pin_pa, pin_po, pin_pw,
    input  kb_code, kb_stat, kb_irq
  );

  modport slave (
    input  ps2_data, ps2_toggle, pin_pa, pin_po, pin_pw,
    output kb_code, kb_stat, kb_irq
  );
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO.
// Synchronises the PS/2 receiver's byte toggle into the CPU clock domain, folds
// E0/F0 prefixes into extended/release flags and queues {ext, rel, code}
// entries. The CPU pops or clears the queue by writing to port PORT_POP.
// Ports:
//   pin_clk  : CPU clock, all state on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : kbd_fifo_if.slave (PS/2 handoff, CPU port writes, status outputs)
//              kb_code = head scancode (00 when empty)
//              kb_stat = {nonempty, overflow, head ext, head rel, count[3:0]}
//              kb_irq  = registered nonempty
module kbd_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [7:0]  PORT_POP = 8'hFD
) (
  input  logic     pin_clk,
  input  logic     reset_n,
  kbd_fifo_if.slave bus
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DepthCnt = 4'(DEPTH);

  typedef enum logic [1:0] {StIdle, StExt, StRel, StExtRel} state_e;

  // Toggle synchroniser: two metastability stages plus one edge-detect stage.
  logic sync1_q, sync2_q, sync3_q;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic [9:0]        mem_q [DEPTH];

  logic       byte_evt;
  logic       is_e0, is_f0, is_err;
  logic       push_req, pop_req, clr_req, port_hit;
  logic       do_push, do_pop;
  logic       empty, full;
  logic       mem_we;
  logic [9:0] push_entry;
  logic [9:0] head;

  always_comb begin
    byte_evt = sync2_q ^ sync3_q;
    is_e0    = (bus.ps2_data == 8'hE0);
    is_f0    = (bus.ps2_data == 8'hF0);
    is_err   = (bus.ps2_data == 8'h00) || (bus.ps2_data == 8'hFF);

    // Prefix decoder: E0/F0 only move the FSM; any real code resets it.
    state_d  = state_q;
    push_req = 1'b0;
    if (byte_evt) begin
      if (is_e0) begin
        state_d = StExt;
      end else if (is_f0) begin
        state_d = (state_q == StExt || state_q == StExtRel) ? StExtRel : StRel;
      end else if (is_err) begin
        state_d = StIdle;
      end else begin
        push_req = 1'b1;
        state_d  = StIdle;
      end
    end

    push_entry = {(state_q == StExt) || (state_q == StExtRel),
                  (state_q == StRel) || (state_q == StExtRel),
                  bus.ps2_data};

    port_hit = bus.pin_pw && (bus.pin_pa == PORT_POP);
    pop_req  = port_hit && !bus.pin_po[7];
    clr_req  = port_hit &&  bus.pin_po[7];

    empty = (count_q == 4'd0);
    full  = (count_q == DepthCnt);

    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    do_pop  = pop_req && !empty;
    do_push = push_req && (!full || do_pop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;

    if (clr_req) begin
      // Clear beats a coincident push; the prefix FSM still advances.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 4'd0;
      ovf_d    = 1'b0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        mem_we   = 1'b1;
      end
      if (push_req && !do_push) begin
        ovf_d = 1'b1;
      end
      count_d = count_q + {3'b000, do_push} - {3'b000, do_pop};
    end

    irq_d = (count_q != 4'd0);
  end

  always_ff @(posedge pin_clk) begin
    if (!reset_n) begin
      // Loading the live level keeps reset release from looking like a byte.
      sync1_q  <= bus.ps2_toggle;
      sync2_q  <= bus.ps2_toggle;
      sync3_q  <= bus.ps2_toggle;
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= bus.ps2_toggle;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge pin_clk) begin
    if (reset_n && mem_we) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign bus.kb_code = empty ? 8'h00 : head[7:0];
  assign bus.kb_stat = {!empty, ovf_q, !empty && head[9], !empty && head[8], count_q};
  assign bus.kb_irq  = irq_q;

endmodule

// File: doc/kbd_fifo.md
KBD_FIFO -- requirements
Module: kbd_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two; count fits in 4 bits.
REQ-002 Parameter PORT_POP, default 8'hFD: CPU output port address that pops or clears the FIFO.
REQ-003 pin_clk  in  1  single clock, CPU clock (25 MHz); all state on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 ps2_data  in  8  received PS/2 byte; stable from a ps2_toggle change until 3 pin_clk edges after it.
REQ-006 ps2_toggle  in  1  inverts once per new byte from the receiver; asynchronous to pin_clk.
REQ-007 pin_pa  in  8  CPU port address.
REQ-008 pin_po  in  8  CPU port write data.
REQ-009 pin_pw  in  1  CPU port write strobe, one pin_clk cycle per OUT.
REQ-010 kb_code  out  8  head-entry scancode; 8'h00 when empty.
REQ-011 kb_stat  out  8  [7] nonempty, [6] overflow, [5] head extended, [4] head release, [3:0] count.
REQ-012 kb_irq  out  1  registered; high while FIFO nonempty.

Function
REQ-013 ps2_toggle SHALL pass a 2-flop synchronizer plus a third edge-detect flop; a byte event SHALL be recognised when the last two stages differ.
REQ-014 A byte event SHALL update state at the 3rd rising edge after the ps2_toggle change; kb_stat/kb_code SHALL reflect it immediately after that edge.
REQ-015 Prefix FSM states: IDLE, EXT, REL, EXT_REL.
REQ-016 Byte E0: IDLE→EXT; REL→EXT; EXT_REL→EXT; EXT→EXT; nothing pushed.
REQ-017 Byte F0: IDLE→REL; EXT→EXT_REL; REL and EXT_REL unchanged; nothing pushed.
REQ-018 Bytes 00 or FF (receiver error): nothing pushed; FSM→IDLE.
REQ-019 Any other byte: push entry {ext, rel, byte}, with ext=1 in EXT/EXT_REL and rel=1 in REL/EXT_REL; FSM→IDLE.
REQ-020 Entry width 10 bits; storage DEPTH×10; circular read and write pointers of log2(DEPTH) bits wrap from DEPTH-1 to 0.
REQ-021 Pop request: pin_pw=1, pin_pa=PORT_POP, pin_po[7]=0.
REQ-022 Clear request: pin_pw=1, pin_pa=PORT_POP, pin_po[7]=1; empties the FIFO, zeroes pointers and count, clears overflow; FSM unchanged.
REQ-023 Pop when empty SHALL be ignored.
REQ-024 Push when full with no simultaneous pop: entry dropped, overflow set; overflow is sticky until clear or reset.
REQ-025 Push and pop in the same cycle: both performed; count unchanged. If full, no overflow. If empty, the pop is ignored and the push is performed, so count becomes 1.
REQ-026 Clear and push in the same cycle: clear wins; the pushed byte is discarded; FSM still updates per REQ-016 to REQ-019.
REQ-027 Count SHALL saturate at DEPTH and never go below 0; kb_stat[3:0] SHALL equal count.
REQ-028 When empty: kb_code=8'h00 and kb_stat[5:4]=00.
REQ-029 kb_irq SHALL equal registered (count≠0), lagging count by one cycle.
REQ-030 Writes to any other port address SHALL have no effect.

Reset
REQ-031 With reset_n=0 at a rising edge, the following SHALL hold after that edge: pointers=0, count=0, overflow=0, FSM=IDLE, kb_irq=0, kb_code=8'h00, kb_stat=8'h00.
REQ-032 Synchronizer flops SHALL load the current ps2_toggle level on reset, so no spurious byte event occurs after reset release.
REQ-033 Reset mid-sequence (e.g. after E0) SHALL discard the prefix; the next plain byte is pushed with ext=0.

Verification
REQ-034 Toggle with byte 1C → after 3 edges kb_code=1C, kb_stat=8'h81; kb_irq=1 one cycle later.
REQ-035 Bytes E0, F0, 75 → single entry; kb_code=75, kb_stat=8'hB1.
REQ-036 Nine plain bytes 01..09 with DEPTH=8 → count=8, kb_stat=8'hC8, kb_code=01; write pin_po=8'h80 to FD → kb_stat=8'h00.
REQ-037 FIFO full, then pop coincides with push of 0A → count stays 8, overflow=0; head is the former second entry; 0A becomes the tail.
REQ-038 Pop eight times after eight pushes with pointers starting at 6 → entries return in order across the wrap; a ninth pop leaves kb_stat=8'h00.
REQ-039 Push E0, then reset_n=0 for one cycle, then push 6B → kb_code=6B, kb_stat=8'h81; toggle held constant through reset produces no entry.
